// File: rtl/player_hit_ctrl_if.sv
// Hit/round bus between the collision logic, the player draw stages and
// the round controller.
interface player_hit_ctrl_if;
    logic       start;
    logic       hit_cat;
    logic       hit_dog;
    logic       cat_flash;
    logic       dog_flash;
    logic [3:0] cat_hp;
    logic [3:0] dog_hp;
    logic [1:0] state;
    logic [1:0] winner;

    modport master (
        output start, hit_cat, hit_dog,
        input  cat_flash, dog_flash, cat_hp, dog_hp, state, winner
    );

    modport slave (
        input  start, hit_cat, hit_dog,
        output cat_flash, dog_flash, cat_hp, dog_hp, state, winner
    );
endinterface

// File: rtl/player_hit_ctrl.sv
// Round controller for the cat/dog sprites: hit edge detect, HP, flash
// (invulnerability) timers and IDLE/PLAY/OVER sequencing with winner report.

// One player: edge detect, HP counter and flash timer.
module player_lane #(
    parameter int MAX_HP      = 5,
    parameter int HIT_DAMAGE  = 1,
    parameter int FLASH_TICKS = 32_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hit,
    input  logic       play,
    input  logic       clear,
    output logic       flash,
    output logic [3:0] hp,
    output logic [3:0] hp_nxt,
    output logic       accept
);
    localparam int         TW    = (FLASH_TICKS > 2) ? $clog2(FLASH_TICKS) : 1;
    localparam logic [3:0] HP0   = 4'(MAX_HP);
    localparam logic [3:0] DMG   = 4'(HIT_DAMAGE);
    localparam logic [TW-1:0] TLOAD = TW'(FLASH_TICKS - 1);

    logic          hit_q;
    logic          hit_rise;
    logic [TW-1:0] timer;

    assign hit_rise = hit & ~hit_q;

    always_comb begin
        accept = hit_rise & play & ~flash;
        hp_nxt = hp;
        // Saturate at zero so large damage never wraps to a high HP.
        if (accept) hp_nxt = (hp > DMG) ? hp - DMG : 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= 1'b0;
            hp    <= HP0;
            flash <= 1'b0;
            timer <= '0;
        end else begin
            hit_q <= hit;
            if (clear) begin
                hp    <= HP0;
                flash <= 1'b0;
                timer <= '0;
            end else if (accept) begin
                hp    <= hp_nxt;
                flash <= 1'b1;
                timer <= TLOAD;
            end else if (flash) begin
                if (timer == '0) flash <= 1'b0;
                else             timer <= timer - TW'(1);
            end
        end
    end
endmodule

module player_hit_ctrl #(
    parameter int MAX_HP      = 5,
    parameter int HIT_DAMAGE  = 1,
    parameter int FLASH_TICKS = 32_500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    player_hit_ctrl_if.slave  bus
);
    localparam int         NUM_LANES = 2;   // lane 0 = cat, lane 1 = dog
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PLAY    = 2'd1;
    localparam logic [1:0] S_OVER    = 2'd2;

    logic [1:0]                  state;
    logic [1:0]                  winner;
    logic                        play;
    logic                        clear;
    logic [NUM_LANES-1:0]        hit;
    logic [NUM_LANES-1:0]        flash;
    logic [NUM_LANES-1:0]        accept;
    logic [NUM_LANES-1:0][3:0]   hp;
    logic [NUM_LANES-1:0][3:0]   hp_nxt;
    logic [NUM_LANES-1:0]        hp_zero;

    assign hit   = {bus.hit_dog, bus.hit_cat};
    assign play  = (state == S_PLAY);
    assign clear = bus.start & (state != S_PLAY);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        player_lane #(
            .MAX_HP      (MAX_HP),
            .HIT_DAMAGE  (HIT_DAMAGE),
            .FLASH_TICKS (FLASH_TICKS)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .hit    (hit[g]),
            .play   (play),
            .clear  (clear),
            .flash  (flash[g]),
            .hp     (hp[g]),
            .hp_nxt (hp_nxt[g]),
            .accept (accept[g])
        );
        assign hp_zero[g] = (hp_nxt[g] == 4'd0);
    end

    // Winner encoding falls out as {cat dead, dog dead}: 2=dog won, 1=cat won, 3=draw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            winner <= 2'd0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) state <= S_PLAY;
                S_PLAY: if (|hp_zero) begin
                    state  <= S_OVER;
                    winner <= {hp_zero[0], hp_zero[1]};
                end
                S_OVER: if (bus.start) begin
                    state  <= S_PLAY;
                    winner <= 2'd0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cat_flash = flash[0];
    assign bus.dog_flash = flash[1];
    assign bus.cat_hp    = hp[0];
    assign bus.dog_hp    = hp[1];
    assign bus.state     = state;
    assign bus.winner    = winner;
endmodule
